// File: rtl/prog_loader.sv
// prog_loader: byte-stream loader that fills 9-bit instruction memory and holds the CPU in reset meanwhile.
// Optional build macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte verified before release.
`default_nettype none

module prog_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [8:0]        wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              err
);

  localparam int LEN_W = ADDR_W + 1;

  localparam logic [2:0] S_LEN_LO = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_W_LO   = 3'd2;
  localparam logic [2:0] S_W_HI   = 3'd3;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK    = 3'd4;
  localparam logic [2:0] S_FINAL  = S_CHK;
`else
  localparam logic [2:0] S_FINAL  = 3'd5;
`endif
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [7:0]        lo_q, lo_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [8:0]        wr_data_q, wr_data_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_done_q, load_done_d;
  logic              err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  logic              accept;
  logic [LEN_W-1:0]  new_len;

  assign accept  = in_valid & in_ready_q;
  assign new_len = LEN_W'({in_data[2:0], len_q[7:0]});

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    lo_d      = lo_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d     = xor_q;
    if (accept && state_q != S_CHK) xor_d = xor_q ^ in_data;
`endif
    case (state_q)
      S_LEN_LO: if (accept) begin
        len_d   = {len_q[LEN_W-1:8], in_data};
        state_d = S_LEN_HI;
      end
      S_LEN_HI: if (accept) begin
        len_d = new_len;
        if (in_data[7:3] != 5'd0 || new_len > LEN_W'(DEPTH)) begin
          state_d = S_ERR;
        end else if (new_len == '0) begin
          state_d = S_FINAL;
        end else begin
          idx_d   = '0;
          state_d = S_W_LO;
        end
      end
      S_W_LO: if (accept) begin
        lo_d    = in_data;
        state_d = S_W_HI;
      end
      S_W_HI: if (accept) begin
        if (in_data[7:1] != 7'd0) begin
          state_d = S_ERR;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q[ADDR_W-1:0];
          wr_data_d = {in_data[0], lo_q};
          idx_d     = idx_q + LEN_W'(1);
          state_d   = (idx_q == len_q - LEN_W'(1)) ? S_FINAL : S_W_LO;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: if (accept) begin
        state_d = (in_data == xor_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: if (start) begin
        state_d = S_LEN_LO;
`ifdef LOADER_CHECKSUM_EN
        xor_d   = 8'd0;
`endif
      end
      default: state_d = S_LEN_LO;
    endcase
  end

  // Status outputs are registered from the next state so they move in the cycle after the deciding byte.
  always_comb begin
    in_ready_d  = (state_d != S_DONE) && (state_d != S_ERR);
    cpu_hold_d  = (state_d != S_DONE);
    load_done_d = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LEN_LO;
      len_q       <= '0;
      idx_q       <= '0;
      lo_q        <= 8'd0;
      in_ready_q  <= 1'b1;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 9'd0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      lo_q        <= lo_d;
      in_ready_q  <= in_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      err_q       <= err_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q       <= xor_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized loads of prog_loader checked against a stream-parsing reference model.
`default_nettype none

module tb_prog_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [8:0]        wr_data;
  logic              cpu_hold;
  logic              load_done;
  logic              err;

  prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] stream[$];
  int exp_addr[$], exp_data[$];
  int got_addr[$], got_data[$];
  int n_use;
  logic exp_ok, exp_last_wr;
  logic start_noise = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      got_addr.push_back(int'(wr_addr));
      got_data.push_back(int'(wr_data));
    end
  end

  // Reference: parse the byte stream by the loader's rules and predict writes and outcome.
  task automatic model_run();
    int len, lo, hi;
    logic [7:0] x;
    exp_addr.delete(); exp_data.delete();
    exp_ok = 1'b0; exp_last_wr = 1'b0;
    len   = int'(stream[0]) + 256 * int'(stream[1]);
    n_use = 2;
    if (stream[1] > 8'd7 || len > DEPTH) return;
    for (int w = 0; w < len; w++) begin
      lo = int'(stream[2 + 2*w]);
      hi = int'(stream[3 + 2*w]);
      n_use += 2;
      if (hi > 1) return;
      exp_addr.push_back(w);
      exp_data.push_back(hi * 256 + lo);
    end
`ifdef LOADER_CHECKSUM_EN
    x = 8'd0;
    for (int i = 0; i < n_use; i++) x ^= stream[i];
    exp_ok = (stream[n_use] == x);
    n_use += 1;
`else
    exp_ok      = 1'b1;
    exp_last_wr = (len > 0);
`endif
  endtask

  task automatic build(input int len, input int bad, input int ck_delta);
    logic [7:0] b, x;
    stream.delete();
    b = len[7:0];      stream.push_back(b);
    b = 8'(len >> 8);  stream.push_back(b);
    for (int w = 0; w < len; w++) begin
      b = 8'($urandom);
      stream.push_back(b);
      if (w == bad) b = 8'($urandom_range(2, 255));
      else          b = 8'($urandom_range(0, 1));
      stream.push_back(b);
    end
    x = 8'd0;
    foreach (stream[i]) x ^= stream[i];
    x = x + 8'(ck_delta);
    stream.push_back(x);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    check("in_ready_rx", in_ready, 1'b1);
    check("cpu_hold_rx", cpu_hold, 1'b1);
    check("load_done_rx", load_done, 1'b0);
    in_data  = b;
    in_valid = 1'b1;
    if (start_noise) start = 1'($urandom);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic compare_writes();
    check("wr_count", got_addr.size(), exp_addr.size());
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      check("wr_addr", got_addr[i], exp_addr[i]);
      check("wr_data", got_data[i], exp_data[i]);
    end
  endtask

  task automatic run_load(input int min_gap, input int max_gap);
    model_run();
    got_addr.delete(); got_data.delete();
    for (int i = 0; i < n_use; i++) send_byte(stream[i], $urandom_range(min_gap, max_gap));
    @(negedge clk);
    check("load_done_end", load_done, exp_ok);
    check("err_end", err, !exp_ok);
    check("cpu_hold_end", cpu_hold, !exp_ok);
    check("in_ready_end", in_ready, 1'b0);
    check("wr_en_last", wr_en, exp_last_wr);
    @(negedge clk);
    check("wr_en_pulse", wr_en, 1'b0);
    compare_writes();
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("start_err", err, 1'b0);
    check("start_ready", in_ready, 1'b1);
    check("start_hold", cpu_hold, 1'b1);
    check("start_done", load_done, 1'b0);
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_cpu_hold", cpu_hold, 1'b1);
    check("rst_load_done", load_done, 1'b0);
    check("rst_err", err, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_data = 8'd0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals();

    // Directed 3-word load, back-to-back then gapped
    stream = '{8'h03, 8'h00, 8'h12, 8'h01, 8'h34, 8'h00, 8'hFF, 8'h01, 8'h03^8'h12^8'h01^8'h34^8'hFF^8'h01};
    run_load(0, 0);
    do_start();
    run_load(1, 3);
    do_start();

    // Oversized header, then recovery load
    stream = '{8'h01, 8'h04, 8'h00};
    run_load(0, 1);
    do_start();
    stream = '{8'h01, 8'h00, 8'hAA, 8'h00, 8'hAB};
    run_load(0, 2);
    do_start();

    // Bad high byte on the third word
    build(4, 2, 0);
    run_load(0, 2);
    do_start();

    // Reset after two of three words
    build(3, -1, 0);
    got_addr.delete(); got_data.delete();
    for (int i = 0; i < 6; i++) send_byte(stream[i], $urandom_range(0, 2));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals();
    build(3, -1, 0);
    run_load(0, 2);
    do_start();

    // Zero-length header and full-depth load
    build(0, -1, 0);
    run_load(0, 1);
    do_start();
    build(DEPTH, -1, 0);
    run_load(0, 0);
    do_start();

`ifdef LOADER_CHECKSUM_EN
    build(3, -1, 1);
    run_load(0, 1);
    do_start();
`endif

    // Randomized loads, with ignored start pulses during reception
    start_noise = 1'b1;
    for (int t = 0; t < 25; t++) begin
      case ($urandom_range(0, 5))
        0:       begin stream = '{8'($urandom), 8'($urandom_range(8, 255)), 8'h00}; end
        1:       build($urandom_range(1, 8), $urandom_range(0, 7), 0);
`ifdef LOADER_CHECKSUM_EN
        2:       build($urandom_range(0, 6), -1, $urandom_range(1, 255));
`endif
        default: build($urandom_range(0, 8), -1, 0);
      endcase
      run_load(0, 3);
      do_start();
    end
    start_noise = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
